// File: rtl/ce_frame_pkg.sv
// Shared types and default sizing for the ce_frame serial transmitter.
// FRAME_LEN_DEF sets the frame width in bits and GAP_LEN_DEF the minimum number of idle cycles between frames.
package ce_frame_pkg;

    localparam int FRAME_LEN_DEF = 16;
    localparam int GAP_LEN_DEF   = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/ce_frame_shifter.sv
// Load/shift register with a per-frame bit counter; last flags the final bit of a frame.
// Latency: msb is valid 1 cycle after load. No backpressure; the controller sequences load, shift and clr.
module ce_frame_shifter
    import ce_frame_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 shift,
    input  logic                 clr,
    input  logic [FRAME_LEN-1:0] data,
    output logic                 msb,
    output logic                 last
);

    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN);

    logic [FRAME_LEN-1:0] sr;
    logic [CW-1:0]        cnt;

    // cnt holds the 1-based index of the bit currently on msb, so it tops out at FRAME_LEN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= data;
            cnt <= CW'(1);
        end else if (clr) begin
            sr  <= '0;
            cnt <= '0;
        end else if (shift) begin
            sr  <= {sr[FRAME_LEN-2:0], 1'b0};
            cnt <= cnt + CW'(1);
        end
    end

    assign msb  = sr[FRAME_LEN-1];
    assign last = (cnt == CNT_LAST);

endmodule

// File: rtl/ce_frame_tx.sv
// Serialises one FRAME_LEN word MSB first under a ce strobe, then holds ce low for GAP_LEN cycles.
// Latency: ce rises 1 cycle after the valid/ready handshake. Backpressure: ready is high only when idle.
// Defining CE_FRAME_TX_PARITY_EN drives the word's even parity on dout in the first cycle after a full frame.
module ce_frame_tx
    import ce_frame_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int GAP_LEN   = GAP_LEN_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic [FRAME_LEN-1:0] data,
    output logic                 ready,
    input  logic                 abort,
    output logic                 ce,
    output logic                 dout,
    output logic                 frame_done
);

`ifdef CE_FRAME_TX_PARITY_EN
    localparam int GAP_CYC = (GAP_LEN < 1) ? 1 : GAP_LEN;
`else
    localparam int GAP_CYC = GAP_LEN;
`endif
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC);

    state_t        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          rst_done;
    logic          load, shift, clr, done_d;
    logic          msb, last;

    ce_frame_shifter #(.FRAME_LEN(FRAME_LEN)) u_shifter (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .clr   (clr),
        .data  (data),
        .msb   (msb),
        .last  (last)
    );

    // rst_done holds ready low until the first edge after reset is released
    assign ready = (state_q == IDLE) && rst_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gap_q      <= '0;
            rst_done   <= 1'b0;
            ce         <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            rst_done   <= 1'b1;
            ce         <= (state_d == SEND);
            frame_done <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        load    = 1'b0;
        shift   = 1'b0;
        clr     = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid && ready) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                // abort wins over the final bit so a truncated frame never reports done
                if (abort || last) begin
                    state_d = GAP;
                    clr     = 1'b1;
                    gap_d   = GW'(1);
                    done_d  = !abort;
                end else begin
                    shift = 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef CE_FRAME_TX_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (load) begin
            parity_q <= ^data;
        end
    end

    // frame_done marks exactly the first gap cycle after a completed frame
    assign dout = ce ? msb : (frame_done & parity_q);
`else
    assign dout = ce & msb;
`endif

endmodule

// File: tb/tb_ce_frame_tx.sv
// Directed plus randomized bench for ce_frame_tx, checked against a frame-timeline reference model.
module tb_ce_frame_tx;
    import ce_frame_pkg::*;

    localparam int F = FRAME_LEN_DEF;
    localparam int G = GAP_LEN_DEF;
`ifdef CE_FRAME_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         valid = 1'b0;
    logic         abort = 1'b0;
    logic [F-1:0] data = '0;
    logic         ready, ce, dout, frame_done;

    always #5 clk = ~clk;

    ce_frame_tx #(.FRAME_LEN(F), .GAP_LEN(G)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid),
        .data       (data),
        .ready      (ready),
        .abort      (abort),
        .ce         (ce),
        .dout       (dout),
        .frame_done (frame_done)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: the current frame is described by its first/last ce cycle and the last gap cycle.
    int           f_start = 0;
    int           f_end   = -10;
    int           gap_end = -10;
    bit           aborted = 1'b0;
    bit           up      = 1'b0;
    logic [F-1:0] word    = '0;

    int run        = 0;
    int last_pulse = 0;
    int done_seen  = 0;
    int done_mark  = 0;

    task automatic check(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        total++;
        assert (got == exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Called at posedge+1: drive inputs, compare this cycle's outputs, advance model across the edge.
    task automatic step(input logic v, input logic [F-1:0] d, input logic a);
        logic e_ce, e_dout, e_done, e_rdy;
        valid = v;
        data  = d;
        abort = a;
        e_ce   = (cyc >= f_start) && (cyc <= f_end);
        e_done = (cyc == f_end + 1) && !aborted;
        e_rdy  = up && (cyc > gap_end);
        e_dout = 1'b0;
        if (e_ce)
            e_dout = word[F-1-(cyc-f_start)];
        else if (PAR && e_done)
            e_dout = ^word;
        check("ce", ce, e_ce);
        check("dout", dout, e_dout);
        check("frame_done", frame_done, e_done);
        check("ready", ready, e_rdy);
        if (ce) run++;
        else if (run != 0) begin
            last_pulse = run;
            run = 0;
        end
        if (frame_done) done_seen++;
        if (e_ce && a) begin
            f_end   = cyc;
            aborted = 1'b1;
            gap_end = cyc + G;
        end else if (e_rdy && v) begin
            f_start = cyc + 1;
            f_end   = cyc + F;
            word    = d;
            aborted = 1'b0;
            gap_end = cyc + F + G;
        end
        up = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Asserts rst between edges, checks outputs before any clock edge, releases it two edges later.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_ce", ce, 1'b0);
        check("rst_dout", dout, 1'b0);
        check("rst_done", frame_done, 1'b0);
        check("rst_ready", ready, 1'b0);
        f_start = 0;
        f_end   = -10;
        gap_end = -10;
        aborted = 1'b0;
        up      = 1'b0;
        run     = 0;
        valid   = 1'b0;
        abort   = 1'b0;
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        check("rst_hold_ready", ready, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_release_ready", ready, 1'b0);
    endtask

    initial begin
        do_reset();
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);

        // single frame A5C3, abort toggled outside SEND afterwards
        done_mark = done_seen;
        step(1'b1, 16'hA5C3, 1'b0);
        repeat (F) step(1'b0, F'($urandom), 1'b0);
        step(1'b0, F'($urandom), 1'b1);
        repeat (3) step(1'b0, '0, 1'b1);
        check_int("single_pulse_len", last_pulse, F);
        check_int("single_done_cnt", done_seen - done_mark, 1);

        // valid held over three frames
        repeat (3 * (F + G + 1)) step(1'b1, F'($urandom), 1'b0);
        check_int("b2b_pulse_len", last_pulse, F);
        repeat (F + G + 2) step(1'b0, F'($urandom), 1'b0);

        // abort in 5th ce-high cycle
        done_mark = done_seen;
        step(1'b1, F'($urandom), 1'b0);
        repeat (4) step(1'b0, F'($urandom), 1'b0);
        step(1'b0, F'($urandom), 1'b1);
        step(1'b0, '0, 1'b0);
        check_int("short_pulse_len", last_pulse, 5);
        if (last_pulse < F) $display("short ce pulse (%0d cycles)", last_pulse);
        repeat (G + 2) step(1'b0, '0, 1'b0);
        check_int("short_done_cnt", done_seen - done_mark, 0);

        // abort on last ce-high cycle with valid/data churning during SEND
        done_mark = done_seen;
        step(1'b1, F'($urandom), 1'b0);
        repeat (F - 1) step(1'($urandom_range(0, 1)), F'($urandom), 1'b0);
        step(1'b1, F'($urandom), 1'b1);
        step(1'b0, '0, 1'b0);
        check_int("last_abort_pulse_len", last_pulse, F);
        repeat (G + 2) step(1'b0, '0, 1'b0);
        check_int("last_abort_done_cnt", done_seen - done_mark, 0);

        // parity bit after frame 0001
        step(1'b1, 16'h0001, 1'b0);
        repeat (F) step(1'b0, '0, 1'b0);
        check("parity_dout", dout, PAR);
        repeat (G + 2) step(1'b0, '0, 1'b0);

        // random traffic with occasional aborts
        repeat (300) step(1'($urandom_range(0, 1)), F'($urandom), ($urandom_range(0, 19) == 0));
        repeat (F + G + 2) step(1'b0, '0, 1'b0);

        // reset in the 8th ce-high cycle
        step(1'b1, F'($urandom), 1'b0);
        repeat (7) step(1'b0, F'($urandom), 1'b0);
        check("pre_rst_ce", ce, 1'b1);
        do_reset();
        step(1'b1, F'($urandom), 1'b0);
        step(1'b1, F'($urandom), 1'b0);
        repeat (F + G + 2) step(1'b0, F'($urandom), 1'b0);
        check_int("post_rst_pulse_len", last_pulse, F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ce_frame_tx.md
CE_FRAME_TX -- requirements
Module: ce_frame_tx

Interface
REQ-001 Parameter FRAME_LEN, default 16, SHALL set the ce pulse width in clk cycles and the data word width (legal range 2..64).
REQ-002 Parameter GAP_LEN, default 1, SHALL set the minimum number of ce-low cycles between frames (legal range 1..255).
REQ-003 Port clk  input  1  SHALL be the single clock; all logic is posedge clk.
REQ-004 Port rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 Port valid  input  1  SHALL indicate that a frame word is offered on data.
REQ-006 Port data  input  FRAME_LEN  SHALL carry the parallel frame word.
REQ-007 Port ready  output  1  SHALL indicate that a word is accepted on this cycle if valid is high.
REQ-008 Port abort  input  1  SHALL request early termination of the current frame.
REQ-009 Port ce  output  1  SHALL be the registered frame-enable strobe.
REQ-010 Port dout  output  1  SHALL be the serial data bit, MSB first, meaningful only while ce is high.
REQ-011 Port frame_done  output  1  SHALL pulse for one cycle when a full-length frame completes.

Function
REQ-012 The FSM SHALL have the states IDLE, SEND and GAP; ready SHALL be high only in IDLE.
REQ-013 When valid and ready are both high at a clock edge, the block SHALL capture data into a shift register and enter SEND; ce SHALL go high and dout SHALL equal data[FRAME_LEN-1] on the following cycle (latency 1).
REQ-014 In SEND, ce SHALL stay high for exactly FRAME_LEN consecutive cycles, and dout SHALL shift left one bit per cycle.
REQ-015 After the FRAME_LEN-th ce-high cycle, ce SHALL go low, frame_done SHALL be high for that first ce-low cycle only, and the FSM SHALL enter GAP.
REQ-016 GAP SHALL last exactly GAP_LEN cycles with ce, ready and dout low, and the FSM SHALL then return to IDLE.
REQ-017 With valid held high, back-to-back frames SHALL therefore be separated by exactly GAP_LEN+1 ce-low cycles.
REQ-018 An abort sampled high in SEND SHALL drive ce low on the next cycle, suppress frame_done and enter GAP (deliberate short pulse); abort outside SEND SHALL be ignored.
REQ-019 An abort sampled on the same edge as the last ce-high cycle SHALL take priority and suppress frame_done.
REQ-020 The bit counter SHALL be ceil(log2(FRAME_LEN+1)) bits wide and SHALL never wrap within a frame.
REQ-021 valid or data changes outside IDLE SHALL have no effect.

Reset
REQ-022 Asserting rst SHALL immediately force IDLE with ce=0, dout=0, frame_done=0, ready=0, and clear the shift register and counters, including mid-frame.
REQ-023 ready SHALL rise on the first clk edge after rst deasserts.

Configuration
REQ-024 With CE_FRAME_TX_PARITY_EN defined, the first GAP cycle after a completed frame SHALL drive dout to the even parity of the captured word while ce is low, and GAP SHALL be lengthened to max(GAP_LEN,1) cycles.
REQ-025 Without CE_FRAME_TX_PARITY_EN, dout SHALL be 0 whenever ce is low, and no parity logic SHALL be present.

Structure
REQ-026 A shared package ce_frame_pkg SHALL hold the state enum (IDLE/SEND/GAP) and the default constants FRAME_LEN_DEF=16 and GAP_LEN_DEF=1.
REQ-027 A sub-module ce_frame_shifter SHALL implement the load/shift register and the bit counter; the FSM SHALL reside in ce_frame_tx.

Verification
REQ-028 Single frame data=16'hA5C3 with valid for 1 cycle -> ce high exactly 16 cycles starting 1 cycle after the handshake; dout = 1010_0101_1100_0011; frame_done is high 1 cycle.
REQ-029 Continuous valid over 3 frames with GAP_LEN=1 -> 16 ce-high cycles, then 2 ce-low cycles, repeated; the external 16-cycle pulse checker reports no errors.
REQ-030 abort in the 5th ce-high cycle -> ce falls after the 5th high cycle; frame_done stays 0; the pulse checker reports "short ce pulse".
REQ-031 rst asserted in the 8th ce-high cycle -> ce drops 0 without waiting for clk; ready rises 1 edge after rst deasserts.
REQ-032 Abort on the last ce-high cycle, plus valid toggling during SEND -> frame_done=0, and the in-flight data is unchanged.
REQ-033 CE_FRAME_TX_PARITY_EN build with data=16'h0001 -> dout=1 in the first cycle after ce falls; without the macro, dout=0 in that cycle.
